// File: rtl/exe_mem_pipe_stage.sv
// EXE->MEM pipeline stage with a valid/ready handshake, bubble-safe outputs and a stall counter.
// Define EXE_MEM_SKID_EN for the 2-entry skid buffer (registered in_ready); otherwise single entry.
module exe_mem_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              WB_EN_IN,
  input  logic              MEM_R_EN_IN,
  input  logic              MEM_W_EN_IN,
  input  logic [DATA_W-1:0] ALU_Res_IN,
  input  logic [DATA_W-1:0] Val_Rm_IN,
  input  logic [DEST_W-1:0] Dest_IN,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              WB_EN,
  output logic              MEM_R_EN,
  output logic              MEM_W_EN,
  output logic [DATA_W-1:0] ALU_Res,
  output logic [DATA_W-1:0] Val_Rm,
  output logic [DEST_W-1:0] Dest,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int ENTRY_W = 3 + 2 * DATA_W + DEST_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [ENTRY_W-1:0] main_reg, main_next;
`ifdef EXE_MEM_SKID_EN
  logic [ENTRY_W-1:0] skid_reg, skid_next;
`endif
  logic [CNT_W-1:0]   stall_cnt_reg, stall_cnt_next;
  logic [ENTRY_W-1:0] in_entry;
  logic               out_valid_int;
  logic               push;
  logic               pop;
  logic               stall_inc;

  assign in_entry      = {WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, ALU_Res_IN, Val_Rm_IN, Dest_IN};
  assign out_valid_int = (state_reg != EMPTY);

`ifdef EXE_MEM_SKID_EN
  // Depends only on the state register, so out_ready never reaches in_ready.
  assign in_ready = (state_reg != TWO) & ~freeze;
`else
  assign in_ready = (~out_valid_int | out_ready) & ~freeze;
`endif

  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid_int & out_ready & ~freeze;
  assign stall_inc = in_valid & ~in_ready & ~freeze & ~flush;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
`ifdef EXE_MEM_SKID_EN
    skid_next  = skid_reg;
`endif
    if (flush) begin
      state_next = EMPTY;
    end else if (!freeze) begin
      case (state_reg)
        EMPTY: begin
          if (push) begin
            state_next = ONE;
            main_next  = in_entry;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_next = in_entry;
`ifdef EXE_MEM_SKID_EN
          end else if (push) begin
            skid_next  = in_entry;
            state_next = TWO;
`endif
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
`ifdef EXE_MEM_SKID_EN
        TWO: begin
          if (pop) begin
            main_next  = skid_reg;
            state_next = ONE;
          end
        end
`endif
        default: state_next = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (stall_inc && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_next = stall_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= EMPTY;
      main_reg      <= '0;
`ifdef EXE_MEM_SKID_EN
      skid_reg      <= '0;
`endif
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      main_reg      <= main_next;
`ifdef EXE_MEM_SKID_EN
      skid_reg      <= skid_next;
`endif
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  // Bubbles present all-zero control and data so MEM never acts on stale fields.
  assign {WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, Dest} =
      out_valid_int ? main_reg : {ENTRY_W{1'b0}};
  assign out_valid = out_valid_int;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_exe_mem_pipe_stage.sv
// Scoreboard bench for exe_mem_pipe_stage: stimulus pushes expected entries, a negedge monitor compares.
module tb_exe_mem_pipe_stage;

  localparam int DATA_W  = 32;
  localparam int DEST_W  = 4;
  localparam int CNT_W   = 4;
  localparam int ENTRY_W = 3 + 2 * DATA_W + DEST_W;
`ifdef EXE_MEM_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, freeze, flush, in_valid, out_ready;
  logic in_ready, out_valid;
  logic WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN;
  logic [DATA_W-1:0] ALU_Res_IN, Val_Rm_IN;
  logic [DEST_W-1:0] Dest_IN;
  logic WB_EN, MEM_R_EN, MEM_W_EN;
  logic [DATA_W-1:0] ALU_Res, Val_Rm;
  logic [DEST_W-1:0] Dest;
  logic [CNT_W-1:0]  stall_cnt;

  logic [ENTRY_W-1:0] drv_entry;
  logic [ENTRY_W-1:0] dut_entry;
  assign {WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, ALU_Res_IN, Val_Rm_IN, Dest_IN} = drv_entry;
  assign dut_entry = {WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, Dest};

  exe_mem_pipe_stage #(.DATA_W(DATA_W), .DEST_W(DEST_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
    .ALU_Res_IN(ALU_Res_IN), .Val_Rm_IN(Val_Rm_IN), .Dest_IN(Dest_IN),
    .out_valid(out_valid), .out_ready(out_ready),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest(Dest), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;
  logic [ENTRY_W-1:0] exp_q[$];
  logic [CNT_W-1:0]   exp_stall = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] mk(input int i);
    logic [31:0] v;
    v = i;
    return {v[0], v[1], ~v[0], 32'h0000_1000 + v, 32'hA500_0000 ^ v, v[3:0]};
  endfunction

  function automatic bit model_ready();
    if (SKID) return (exp_q.size() < 2) && !freeze;
    return ((exp_q.size() == 0) || out_ready) && !freeze;
  endfunction

  // Reference occupancy model: applies the handshake rules at each rising edge.
  initial begin
    bit rdy;
    forever begin
      @(posedge clk);
      started = 1'b1;
      rdy = model_ready();
      if (!rst) begin
        exp_q.delete();
        exp_stall = '0;
      end else if (flush) begin
        exp_q.delete();
      end else if (!freeze) begin
        if (in_valid && !rdy && exp_stall != {CNT_W{1'b1}}) exp_stall = exp_stall + 1'b1;
        if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && rdy) exp_q.push_back(drv_entry);
      end
    end
  end

  // Monitor: whatever the DUT presents must be the oldest accepted entry, or a zero bubble.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("in_ready", 128'(in_ready), 128'(model_ready()));
        chk("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
        chk("stall_cnt", 128'(stall_cnt), 128'(exp_stall));
        if (exp_q.size() > 0) begin
          chk("entry", 128'(dut_entry), 128'(exp_q[0]));
          $display("txn: out ALU_Res=%08h Dest=%0d ready=%0b", ALU_Res, Dest, out_ready);
        end else begin
          chk("bubble", 128'(dut_entry), 128'(0));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    drv_entry = mk(99);
    step(); step();
    @(negedge clk);
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_stall", 128'(stall_cnt), 128'(0));
    chk("reset_alu", 128'(ALU_Res), 128'(0));
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 128'(in_ready), 128'(1));

    // Streaming: eight back-to-back entries.
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; drv_entry = mk(i);
      step();
    end
    in_valid = 1'b0;
    step(); step();

    // Back-pressure from empty.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; drv_entry = mk(16 + i);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_stall_cnt", 128'(stall_cnt), SKID ? 128'(2) : 128'(3));
    @(posedge clk); #1;
    out_ready = 1'b1;
    step(); step(); step();

    // Flush with a full stage and an incoming entry.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; drv_entry = mk(32 + i);
      step();
    end
    flush = 1'b1; drv_entry = mk(40);
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    chk("flush_mem_w", 128'(MEM_W_EN), 128'(0));
    chk("flush_in_ready", 128'(in_ready), 128'(1));

    // Freeze with one entry held.
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; drv_entry = mk(48);
    step();
    freeze = 1'b1; drv_entry = mk(49);
    step(); step(); step();
    @(negedge clk);
    chk("freeze_hold_alu", 128'(ALU_Res), 128'(32'h0000_1030));
    @(posedge clk); #1;
    freeze = 1'b0;
    step();
    drv_entry = mk(50);
    step();
    in_valid = 1'b0;
    step(); step();

    // Saturation of the stall counter.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 22; i++) begin
      drv_entry = mk(64 + i);
      step();
    end
    @(negedge clk);
    chk("sat_stall_cnt", 128'(stall_cnt), 128'(15));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();

    // Reset in the middle of operation.
    out_ready = 1'b0; in_valid = 1'b1; drv_entry = mk(90);
    step();
    drv_entry = mk(91);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("midreset_out_valid", 128'(out_valid), 128'(0));
    chk("midreset_stall", 128'(stall_cnt), 128'(0));
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
